sync_debounce_multi: RTL
========================

// Module: sync_debounce_multi
// PURPOSE
//   WIDTH-channel successor to the single-bit three-flop synchronizer. Per channel:
//   - STAGES-deep synchronizer chain
//   - saturating-counter debouncer
//   - registered rise/fall pulse generation
//   Sits between board pins (buttons/switches) and the game FSMs; downstream logic
//   consumes only level/rise/fall.
// PARAMETERS
//   WIDTH           4   number of independent channels (>=1)
//   STAGES          3   synchronizer flops per channel (>=2)
//   DEBOUNCE_CYCLES 4   consecutive cycles a new synchronized value must hold before acceptance (>=1)
//   CW = $clog2(DEBOUNCE_CYCLES+1) (localparam, counter width)
// PORTS
//   Clk100MHz  in   1      system clock, all flops on posedge
//   reset      in   1      synchronous, active-high reset
//   async_in   in   WIDTH  raw asynchronous inputs
//   level      out  WIDTH  debounced, synchronized level
//   rise       out  WIDTH  1-cycle pulse when level[i] goes 0->1
//   fall       out  WIDTH  1-cycle pulse when level[i] goes 1->0
//   any_rise   out  1      OR-reduction of rise (registered, same cycle as rise)
// BEHAVIOUR
//   Reset (reset=1 at posedge):
//   - All chain flops, counters, level, rise, fall, any_rise <= 0.
//   - reset overrides everything, including an in-progress debounce count.
//   Chain (channel i):
//   - s[0] <= async_in[i]; s[k] <= s[k-1]; s_last = s[STAGES-1].
//   - No logic between chain flops.
//   Debounce (channel i, every posedge, reset=0):
//   - s_last == level[i]: cnt <= 0 (glitch shorter than DEBOUNCE_CYCLES discarded).
//   - s_last != level[i] and cnt == DEBOUNCE_CYCLES-1: level[i] <= s_last; cnt <= 0;
//     rise[i] <= s_last; fall[i] <= ~s_last.
//   - Otherwise: cnt <= cnt+1.
//   - rise/fall are 0 in every cycle not listed above, so each pulse is exactly
//     1 cycle and coincides with the first cycle of the new level.
//   Latency:
//   - async change sampled at edge k -> level/rise/fall change visible after
//     edge k+STAGES+DEBOUNCE_CYCLES-1.
//   - Defaults: 6 edges after the sampling edge.
//   - DEBOUNCE_CYCLES=1: one edge after s_last changes.
//   Boundaries:
//   - cnt never exceeds DEBOUNCE_CYCLES-1; no wrap.
//   - rise and fall never both 1 on one channel.
//   - Input that toggles every cycle never changes level when DEBOUNCE_CYCLES>=2.
//   - Channels fully independent: simultaneous edges on several channels give
//     simultaneous pulses.
//   - Reset asserted mid-count: count lost, level returns 0, no pulse emitted in
//     the reset cycle or the first cycle after release.
//   - Input held 1 through reset release: rise fires STAGES+DEBOUNCE_CYCLES-1
//     edges after release (counting the first post-release sampling edge).
//   - any_rise = |rise computed from next-state values, registered, so it
//     aligns with rise.
// TESTING
//   1. reset=1 for 3 cycles with async_in=4'hF -> level/rise/fall/any_rise all 0 during reset.
//   2. Defaults, async_in[0] 0->1 held -> rise[0]=1 for exactly 1 cycle,
//      6 edges after the sampling edge; level[0]=1 thereafter.
//   3. async_in[1] high for 3 cycles then low (glitch < DEBOUNCE_CYCLES after sync)
//      -> level[1] stays 0, rise[1] never pulses.
//   4. level[2]=1, then async_in[2] 1->0 held -> fall[2] 1-cycle pulse,
//      level[2]=0, rise[2] stays 0.
//   5. async_in=4'b1011 in one cycle from 0 -> rise=4'b1011 and any_rise=1 in the
//      same cycle, one pulse only.
//   6. reset asserted 2 cycles after an input edge mid-debounce -> no pulse; after
//      release, with input still 1, rise fires at the full latency.

Source files
------------

// File: rtl/sync_debounce_multi.sv
// sync_debounce_multi
//   Multi-channel input conditioner for board pins (buttons/switches). Each
//   channel has a STAGES-deep synchronizer chain, then a saturating-counter
//   debouncer, then registered rise/fall pulse generation.
// Ports
//   Clk100MHz : system clock, all flops on posedge
//   reset     : synchronous, active-high reset
//   async_in  : raw asynchronous inputs, one bit per channel
//   level     : debounced, synchronized level
//   rise      : 1-cycle pulse when level[i] goes 0->1
//   fall      : 1-cycle pulse when level[i] goes 1->0
//   any_rise  : OR of rise, registered so it aligns with rise
module sync_debounce_multi #(
  parameter int WIDTH           = 4,
  parameter int STAGES          = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             Clk100MHz,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // sync_q[k] holds stage k of every channel
  logic [WIDTH-1:0] sync_q [STAGES];
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] s_last;
  logic [WIDTH-1:0] level_d;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;

  assign s_last = sync_q[STAGES-1];

  always_ff @(posedge Clk100MHz) begin
    if (reset) begin
      for (int unsigned k = 0; k < STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int unsigned k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  always_comb begin
    level_d = level;
    rise_d  = '0;
    fall_d  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s_last[i] == level[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = s_last[i];
        rise_d[i]  = s_last[i];
        fall_d[i]  = ~s_last[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk100MHz) begin
    if (reset) begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      level    <= '0;
      rise     <= '0;
      fall     <= '0;
      any_rise <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      level    <= level_d;
      rise     <= rise_d;
      fall     <= fall_d;
      // taken from next-state so it lands in the same cycle as rise
      any_rise <= |rise_d;
    end
  end

endmodule
